// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle for the serial adder/subtractor: request operands in, flags and result out.
interface serial_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, co, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, co, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock, a - b computed as a + ~b + 1.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic           clk,
  input  logic           reset,
  serial_addsub_if.slave bus
);
  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, carry_next;
  logic             co_reg, co_next;
  logic             ovf_reg, ovf_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [SLICE-1:0] a_slices [N];
  logic [SLICE-1:0] b_slices [N];
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_slice   = a_slices[idx_reg];
  assign b_slice   = b_slices[idx_reg];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      co_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      carry_reg  <= carry_next;
      co_reg     <= co_next;
      ovf_reg    <= ovf_next;
      idx_reg    <= idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    co_next     = co_reg;
    ovf_next    = ovf_reg;
    idx_next    = idx_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // Subtraction inverts b here and injects the +1 through the initial carry.
          a_next      = bus.a;
          b_next      = bus.sub ? ~bus.b : bus.b;
          carry_next  = bus.sub;
          idx_next    = '0;
          result_next = '0;
          co_next     = 1'b0;
          ovf_next    = 1'b0;
          state_next  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_reg == IDX_W'(i)) begin
            result_next[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
          end
        end
        carry_next = slice_sum[SLICE];
        idx_next   = idx_reg + 1'b1;
        if (idx_reg == LAST) begin
          // Like-signed operands producing an opposite-signed sum is signed overflow.
          co_next    = slice_sum[SLICE];
          ovf_next   = (a_slice[SLICE-1] == b_slice[SLICE-1]) &&
                       (slice_sum[SLICE-1] != a_slice[SLICE-1]);
          idx_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
  assign bus.co     = co_reg;
  assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed vector table plus hand-written abort, ignored-start and back-to-back sequences for serial_addsub.
module tb_serial_addsub;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: signed/unsigned integer arithmetic rather than bit-level carries.
  task automatic model(input logic s, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic co, output logic ovf);
    int sa, sb, sr, ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    sr = s ? (sa - sb) : (sa + sb);
    res = s ? (a - b) : (a + b);
    co  = s ? (ua >= ub) : ((ua + ub) > 65535);
    ovf = (sr > 32767) || (sr < -32768);
  endtask

  // Drives a request for exactly one edge (E0), then scrambles the inputs; returns at the negedge after E0.
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    r = $urandom;
    bus.start = 1'b0;
    bus.sub   = ~s;
    bus.a     = r[15:0];
    bus.b     = r[31:16];
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt, output bit ok);
    cyc = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    ok = (bus.done === 1'b1);
  endtask

  task automatic count_done(input int cycles, output int dones, output int busys);
    dones = 0;
    busys = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busys++;
    end
  endtask

  initial begin
    int cyc, busy_cnt, dones, busys, gap;
    bit ok;
    logic [15:0] er;
    logic ec, eo;
    logic [31:0] r;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, bus.busy}, 32'd0);
    check("reset_done",   {31'd0, bus.done}, 32'd0);
    check("reset_result", {16'd0, bus.result}, 32'd0);
    check("reset_co",     {31'd0, bus.co}, 32'd0);
    check("reset_ovf",    {31'd0, bus.ovf}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].sub, vecs[i].a, vecs[i].b);
      wait_done(cyc, busy_cnt, ok);
      check($sformatf("vec%0d_done_seen", i), {31'd0, ok}, 32'd1);
      // Four edges after E0 (the fifth edge counting E0 itself).
      check($sformatf("vec%0d_latency", i), cyc, 32'd4);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 32'd4);
      check($sformatf("vec%0d_result", i), {16'd0, bus.result}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d_co", i), {31'd0, bus.co}, {31'd0, vecs[i].co});
      check($sformatf("vec%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), {16'd0, bus.result}, {16'd0, vecs[i].res});
      $display("vec %0d: sub=%0d a=%h b=%h -> result=%h co=%0d ovf=%0d", i, vecs[i].sub,
               vecs[i].a, vecs[i].b, bus.result, bus.co, bus.ovf);
    end

    // A start arriving during RUN must be dropped, not queued.
    launch(1'b0, 16'h1111, 16'h1111);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, busy_cnt, ok);
    check("ignore_done_seen", {31'd0, ok}, 32'd1);
    check("ignore_result", {16'd0, bus.result}, 32'h2222);
    check("ignore_co", {31'd0, bus.co}, 32'd0);
    count_done(10, dones, busys);
    check("ignore_extra_done", dones, 32'd0);
    check("ignore_extra_busy", busys, 32'd0);
    $display("ignored start: result=%h extra_done=%0d", bus.result, dones);

    // Reset two edges into RUN aborts the operation silently.
    launch(1'b0, 16'h1234, 16'h0FED);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",   {31'd0, bus.busy}, 32'd0);
    check("abort_done",   {31'd0, bus.done}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_co",     {31'd0, bus.co}, 32'd0);
    check("abort_ovf",    {31'd0, bus.ovf}, 32'd0);
    reset = 1'b0;
    count_done(10, dones, busys);
    check("abort_no_done", dones, 32'd0);
    launch(1'b1, 16'h0007, 16'h0005);
    wait_done(cyc, busy_cnt, ok);
    check("abort_recover_done", {31'd0, ok}, 32'd1);
    check("abort_recover_result", {16'd0, bus.result}, 32'h0002);
    check("abort_recover_co", {31'd0, bus.co}, 32'd1);
    $display("reset abort: recovered result=%h co=%0d", bus.result, bus.co);

    // Start held high: each accepted operation is followed by a new one every six cycles.
    @(negedge clk);
    r = $urandom;
    bus.start = 1'b1;
    bus.sub   = r[0];
    bus.a     = r[31:16];
    r = $urandom;
    bus.b     = r[15:0];
    gap = 0;
    while (bus.busy !== 1'b1 && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_first_accept", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 1000; i++) begin
      model(bus.sub, bus.a, bus.b, er, ec, eo);
      r = $urandom;
      bus.sub = r[0];
      bus.a   = r[31:16];
      r = $urandom;
      bus.b   = r[15:0];
      wait_done(cyc, busy_cnt, ok);
      check("b2b_done_seen", {31'd0, ok}, 32'd1);
      check("b2b_result", {16'd0, bus.result}, {16'd0, er});
      check("b2b_co", {31'd0, bus.co}, {31'd0, ec});
      check("b2b_ovf", {31'd0, bus.ovf}, {31'd0, eo});
      $display("b2b %0d: result=%h co=%0d ovf=%0d", i, bus.result, bus.co, bus.ovf);
      if (i == 999) begin
        bus.start = 1'b0;
      end else begin
        gap = cyc;
        @(negedge clk);
        gap++;
        while (bus.busy !== 1'b1 && gap < 20) begin
          @(negedge clk);
          gap++;
        end
        check("b2b_period", gap, 32'd6);
      end
    end

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
